// File: rtl/bullet_spawner.sv
// Purpose : writer side of the bullet RAM; finds free 4-byte slots and fills them
//           with single / 4-way / 8-way bursts from one origin point.
// Latency : 3 cycles per occupied slot scanned, 8 cycles per bullet written, plus IDLE/DONE.
// Backpressure: level begin_spawn/done handshake; done holds until begin_spawn drops.
// Ports   : clk/reset (sync, active-high); begin_spawn, origin_x/y, pattern, move_code
//           request; DataOut/address/WriteData/RamWrite RAM port; done, spawned, full,
//           bad_req result status (valid from DONE until the next accepted request).
module bullet_spawner #(
    parameter int NUM_SLOTS = 56,
    parameter int X_MAX     = 159,
    parameter int Y_MAX     = 119
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       begin_spawn,
    input  logic [7:0] origin_x,
    input  logic [6:0] origin_y,
    input  logic [1:0] pattern,
    input  logic [3:0] move_code,
    input  logic [7:0] DataOut,
    output logic [7:0] address,
    output logic [7:0] WriteData,
    output logic       RamWrite,
    output logic       done,
    output logic [3:0] spawned,
    output logic       full,
    output logic       bad_req
);

    localparam int SW = $clog2(NUM_SLOTS + 1);
    localparam logic [SW-1:0] SLOTS_N   = SW'(NUM_SLOTS);
    localparam logic [SW-1:0] LAST_SLOT = SW'(NUM_SLOTS - 1);
    localparam logic [7:0]    X_LIM     = 8'(X_MAX);
    localparam logic [6:0]    Y_LIM     = 7'(Y_MAX);

    typedef enum logic [3:0] {
        IDLE, RD, WT, CK, WM, WX, WY, WS, NX, DONE
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] slot_q, slot_d;
    logic [SW-1:0] scan_q, scan_d;
    logic [2:0]    idx_q, idx_d;
    logic [3:0]    spawned_q, spawned_d;
    logic          full_q, full_d;
    logic          bad_q, bad_d;
    logic [7:0]    ox_q, ox_d;
    logic [6:0]    oy_q, oy_d;
    logic [1:0]    pat_q, pat_d;
    logic [3:0]    mv_q, mv_d;

    logic [SW-1:0] slot_next;
    logic [7:0]    slot_base;
    logic [3:0]    burst_len;
    logic [3:0]    cur_code;

    // Burst direction table: axis directions first, then diagonals.
    function automatic logic [3:0] burst_code(input logic [2:0] i);
        case (i)
            3'd0:    burst_code = 4'b1000;
            3'd1:    burst_code = 4'b0100;
            3'd2:    burst_code = 4'b0010;
            3'd3:    burst_code = 4'b0001;
            3'd4:    burst_code = 4'b1010;
            3'd5:    burst_code = 4'b1001;
            3'd6:    burst_code = 4'b0110;
            default: burst_code = 4'b0101;
        endcase
    endfunction

    always_comb begin
        slot_next = (slot_q == LAST_SLOT) ? '0 : slot_q + 1'b1;
        slot_base = 8'({slot_q, 2'b00});
        case (pat_q)
            2'd1:    burst_len = 4'd4;
            2'd2:    burst_len = 4'd8;
            default: burst_len = 4'd1;   // single and reserved
        endcase
        cur_code = (pat_q == 2'd1 || pat_q == 2'd2) ? burst_code(idx_q) : mv_q;
    end

    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        scan_d    = scan_q;
        idx_d     = idx_q;
        spawned_d = spawned_q;
        full_d    = full_q;
        bad_d     = bad_q;
        ox_d      = ox_q;
        oy_d      = oy_q;
        pat_d     = pat_q;
        mv_d      = mv_q;
        address   = 8'h00;
        WriteData = 8'h00;
        RamWrite  = 1'b0;
        done      = 1'b0;

        case (state_q)
            IDLE: begin
                if (begin_spawn) begin
                    ox_d      = origin_x;
                    oy_d      = origin_y;
                    pat_d     = pattern;
                    mv_d      = move_code;
                    spawned_d = '0;
                    full_d    = 1'b0;
                    bad_d     = 1'b0;
                    scan_d    = '0;
                    idx_d     = '0;
                    if (origin_x > X_LIM || origin_y > Y_LIM) begin
                        bad_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            // Address held through WT/CK so the synchronous RAM sees a stable read.
            RD: begin
                address = slot_base;
                state_d = WT;
            end
            WT: begin
                address = slot_base;
                state_d = CK;
            end
            CK: begin
                address = slot_base;
                scan_d  = scan_q + 1'b1;
                if (DataOut[0]) begin
                    if (scan_d == SLOTS_N) begin
                        full_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        slot_d  = slot_next;
                        state_d = RD;
                    end
                end else begin
                    state_d = WM;
                end
            end
            WM: begin
                address   = slot_base + 8'd1;
                WriteData = {4'b0000, cur_code};
                RamWrite  = 1'b1;
                state_d   = WX;
            end
            WX: begin
                address   = slot_base + 8'd2;
                WriteData = ox_q;
                RamWrite  = 1'b1;
                state_d   = WY;
            end
            WY: begin
                address   = slot_base + 8'd3;
                WriteData = {1'b0, oy_q};
                RamWrite  = 1'b1;
                state_d   = WS;
            end
            // Status goes last so an abandoned slot never looks active.
            WS: begin
                address   = slot_base;
                WriteData = 8'h01;
                RamWrite  = 1'b1;
                state_d   = NX;
            end
            NX: begin
                spawned_d = spawned_q + 1'b1;
                idx_d     = idx_q + 1'b1;
                slot_d    = slot_next;
                if (spawned_d == burst_len) begin
                    state_d = DONE;
                end else if (scan_q == SLOTS_N) begin
                    full_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = RD;
                end
            end
            DONE: begin
                done = 1'b1;
                if (!begin_spawn) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            slot_q    <= '0;
            scan_q    <= '0;
            idx_q     <= '0;
            spawned_q <= '0;
            full_q    <= 1'b0;
            bad_q     <= 1'b0;
            ox_q      <= '0;
            oy_q      <= '0;
            pat_q     <= '0;
            mv_q      <= '0;
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            scan_q    <= scan_d;
            idx_q     <= idx_d;
            spawned_q <= spawned_d;
            full_q    <= full_d;
            bad_q     <= bad_d;
            ox_q      <= ox_d;
            oy_q      <= oy_d;
            pat_q     <= pat_d;
            mv_q      <= mv_d;
        end
    end

    assign spawned = spawned_q;
    assign full    = full_q;
    assign bad_req = bad_q;

endmodule

// File: tb/tb_bullet_spawner.sv
// Purpose : self-checking bench for bullet_spawner with a 224-byte synchronous RAM model.
// Latency : RAM read data appears two edges after the address is presented.
// Backpressure: requests held high until done, then dropped.
module tb_bullet_spawner;

    logic       clk = 1'b0;
    logic       reset;
    logic       begin_spawn;
    logic [7:0] origin_x;
    logic [6:0] origin_y;
    logic [1:0] pattern;
    logic [3:0] move_code;
    logic [7:0] DataOut;
    logic [7:0] address;
    logic [7:0] WriteData;
    logic       RamWrite;
    logic       done;
    logic [3:0] spawned;
    logic       full;
    logic       bad_req;

    bullet_spawner dut (
        .clk        (clk),
        .reset      (reset),
        .begin_spawn(begin_spawn),
        .origin_x   (origin_x),
        .origin_y   (origin_y),
        .pattern    (pattern),
        .move_code  (move_code),
        .DataOut    (DataOut),
        .address    (address),
        .WriteData  (WriteData),
        .RamWrite   (RamWrite),
        .done       (done),
        .spawned    (spawned),
        .full       (full),
        .bad_req    (bad_req)
    );

    always #5 clk = ~clk;

    // RAM model plus a one-cycle bulk loader for the status bytes.
    logic [7:0]  mem [0:223];
    logic [7:0]  addr_r;
    logic [55:0] init_act;
    logic        init_req;

    always @(posedge clk) begin
        if (init_req) begin
            for (int k = 0; k < 56; k++) begin
                mem[4*k]   <= {7'b0, init_act[k]};
                mem[4*k+1] <= 8'h00;
                mem[4*k+2] <= 8'h00;
                mem[4*k+3] <= 8'h00;
            end
        end else if (RamWrite) begin
            mem[address] <= WriteData;
        end
        addr_r  <= address;
        DataOut <= mem[addr_r];
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard of expected RAM writes {address, data}, in order.
    logic [15:0] exp_q [$];
    logic [15:0] exp_e;
    logic [3:0]  burst_tbl [0:7];
    int          m_ptr;

    always @(negedge clk) begin
        if (RamWrite === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_write", 32'(RamWrite), 32'd0);
            end else begin
                exp_e = exp_q.pop_front();
                check("ram_write", {16'b0, address, WriteData}, {16'b0, exp_e});
            end
        end
    end

    task automatic load(input logic [55:0] act);
        @(negedge clk);
        init_act = act;
        init_req = 1'b1;
        @(negedge clk);
        init_req = 1'b0;
    endtask

    // Reference plan: walk slots from the model pointer, queueing the writes.
    task automatic plan(input logic [7:0] px, input logic [6:0] py, input logic [1:0] pat,
                        input logic [3:0] code, output int sp, output bit fl);
        int cnt;
        int scan;
        logic [3:0] c;
        logic [7:0] a;
        cnt  = (pat == 2'd1) ? 4 : (pat == 2'd2) ? 8 : 1;
        scan = 0;
        sp   = 0;
        fl   = 0;
        while (1) begin
            scan++;
            if (mem[4*m_ptr][0]) begin
                if (scan == 56) begin fl = 1; break; end
                m_ptr = (m_ptr + 1) % 56;
            end else begin
                c = (cnt == 1) ? code : burst_tbl[sp];
                a = 8'(4*m_ptr);
                exp_q.push_back({a + 8'd1, 4'b0, c});
                exp_q.push_back({a + 8'd2, px});
                exp_q.push_back({a + 8'd3, 1'b0, py});
                exp_q.push_back({a, 8'h01});
                sp++;
                m_ptr = (m_ptr + 1) % 56;
                if (sp == cnt) break;
                if (scan == 56) begin fl = 1; break; end
            end
        end
    endtask

    task automatic run_req(input logic [7:0] px, input logic [6:0] py, input logic [1:0] pat,
                           input logic [3:0] code, input bit bad);
        int sp;
        bit fl;
        int cyc;
        sp = 0;
        fl = 0;
        if (!bad) plan(px, py, pat, code, sp, fl);
        @(negedge clk);
        origin_x    = px;
        origin_y    = py;
        pattern     = pat;
        move_code   = code;
        begin_spawn = 1'b1;
        cyc = 0;
        while (done !== 1'b1 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        check("done_seen", 32'(done), 32'd1);
        check("spawned", 32'(spawned), 32'(sp));
        check("full", 32'(full), 32'(fl));
        check("bad_req", 32'(bad_req), 32'(bad));
        check("writes_left", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clk);
        check("done_hold", 32'(done), 32'd1);
        begin_spawn = 1'b0;
        @(negedge clk);
        check("done_drop", 32'(done), 32'd0);
        check("spawned_keep", 32'(spawned), 32'(sp));
    endtask

    initial begin
        int cyc;
        int t;
        logic [55:0] act;
        burst_tbl[0] = 4'b1000; burst_tbl[1] = 4'b0100;
        burst_tbl[2] = 4'b0010; burst_tbl[3] = 4'b0001;
        burst_tbl[4] = 4'b1010; burst_tbl[5] = 4'b1001;
        burst_tbl[6] = 4'b0110; burst_tbl[7] = 4'b0101;
        reset = 1'b1; begin_spawn = 1'b0; origin_x = '0; origin_y = '0;
        pattern = '0; move_code = '0; init_act = '0; init_req = 1'b0;
        m_ptr = 0;
        load(56'd0);
        repeat (2) @(negedge clk);
        check("rst_address", 32'(address), 32'd0);
        check("rst_wdata", 32'(WriteData), 32'd0);
        check("rst_we", 32'(RamWrite), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_spawned", 32'(spawned), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_bad", 32'(bad_req), 32'd0);
        reset = 1'b0;

        // Single bullet into an empty RAM.
        run_req(8'd80, 7'd60, 2'd0, 4'b1000, 1'b0);
        check("s0_status", 32'(mem[0]), 32'h01);
        check("s0_move", 32'(mem[1]), 32'h08);
        check("s0_x", 32'(mem[2]), 32'h50);
        check("s0_y", 32'(mem[3]), 32'h3C);

        // 4-way with slots 1,2 occupied; pointer is at 1.
        act = '0; act[1] = 1'b1; act[2] = 1'b1;
        load(act);
        run_req(8'd10, 7'd20, 2'd1, 4'b0000, 1'b0);
        check("s3_move", 32'(mem[13]), 32'h08);
        check("s4_move", 32'(mem[17]), 32'h04);
        check("s5_move", 32'(mem[21]), 32'h02);
        check("s6_move", 32'(mem[25]), 32'h01);
        check("s7_untouched", 32'(mem[28]), 32'h00);

        // 53 of 56 occupied, 8-way: three bullets then full.
        act = '1; act[10] = 1'b0; act[30] = 1'b0; act[50] = 1'b0;
        load(act);
        run_req(8'd5, 7'd5, 2'd2, 4'b0000, 1'b0);
        check("full_burst_cnt", 32'(spawned), 32'd3);

        // Out-of-range origins rejected, edge origin accepted.
        load(56'd0);
        run_req(8'd160, 7'd10, 2'd0, 4'b1000, 1'b1);
        run_req(8'd10, 7'd120, 2'd2, 4'b1000, 1'b1);
        run_req(8'd159, 7'd119, 2'd0, 4'b0110, 1'b0);

        // Walk the pointer to 55, then force a wrap onto slot 0.
        act = '1; act[54] = 1'b0;
        load(act);
        run_req(8'd1, 7'd2, 2'd3, 4'b0001, 1'b0);
        act = '1; act[0] = 1'b0;
        load(act);
        run_req(8'd33, 7'd44, 2'd3, 4'b0101, 1'b0);
        check("wrap_status", 32'(mem[0]), 32'h01);
        check("wrap_move", 32'(mem[1]), 32'h05);

        // Reset during the x write: slot stays inactive.
        load(56'd0);
        t = m_ptr;
        exp_q.push_back({8'(4*t + 1), 8'h09});
        exp_q.push_back({8'(4*t + 2), 8'd77});
        @(negedge clk);
        origin_x = 8'd77; origin_y = 7'd7; pattern = 2'd0; move_code = 4'b1001;
        begin_spawn = 1'b1;
        cyc = 0;
        while (!(RamWrite === 1'b1 && address == 8'(4*t + 2)) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("reached_wx", 32'(address), 32'(4*t + 2));
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_address", 32'(address), 32'd0);
        check("mid_rst_wdata", 32'(WriteData), 32'd0);
        check("mid_rst_we", 32'(RamWrite), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_spawned", 32'(spawned), 32'd0);
        begin_spawn = 1'b0;
        m_ptr = 0;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("abandoned_status", 32'(mem[4*t]), 32'h00);
        check("abandoned_move", 32'(mem[4*t+1]), 32'h09);
        check("abandoned_q", 32'(exp_q.size()), 32'd0);

        // Pointer restarts at slot 0 after reset.
        load(56'd0);
        run_req(8'd2, 7'd3, 2'd0, 4'b0010, 1'b0);
        check("post_rst_slot0", 32'(mem[2]), 32'h02);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
